// File: rtl/jk_drive_sequencer.sv
// Drive-side sequencer for a bank of JK latches: setup -> enable pulse -> hold, with a shadow of latch state.
// Optional JK_TOGGLE_DRIVE_EN: changing bits are toggled (J=K=1) with a single-cycle enable pulse.
module jk_drive_sequencer #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             q_sync,
    input  logic [WIDTH-1:0] Q_fb,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             en,
    output logic [WIDTH-1:0] cur_q,
    output logic             busy,
    output logic             done
);

`ifdef JK_TOGGLE_DRIVE_EN
    localparam int SETTLE_EFF = 1;
`else
    localparam int SETTLE_EFF = SETTLE_CYCLES;
`endif
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [WIDTH-1:0]   tgt_q, tgt_d;
    logic [WIDTH-1:0]   j_q, j_d;
    logic [WIDTH-1:0]   k_q, k_d;
    logic               en_q, en_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   exc_j, exc_k;

`ifdef JK_TOGGLE_DRIVE_EN
    assign exc_j = tgt_data ^ shadow_q;
    assign exc_k = tgt_data ^ shadow_q;
`else
    assign exc_j = tgt_data & ~shadow_q;
    assign exc_k = ~tgt_data & shadow_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            tgt_q    <= '0;
            j_q      <= '0;
            k_q      <= '0;
            en_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            tgt_q    <= tgt_d;
            j_q      <= j_d;
            k_q      <= k_d;
            en_q     <= en_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        tgt_d    = tgt_q;
        j_d      = j_q;
        k_d      = k_q;
        en_d     = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (q_sync) begin
                    shadow_d = Q_fb;
                end else if (tgt_valid) begin
                    tgt_d = tgt_data;
                    if (tgt_data != shadow_q) begin
                        state_d = SETUP;
                        j_d     = exc_j;
                        k_d     = exc_k;
                    end else begin
                        state_d = HOLD;
                        j_d     = '0;
                        k_d     = '0;
                    end
                end
            end
            SETUP: begin
                state_d = PULSE;
                en_d    = 1'b1;
                cnt_d   = SETTLE_LOAD;
            end
            PULSE: begin
                // counter holds the number of enable cycles still to come after this one
                if (cnt_q == 8'd0) begin
                    state_d  = HOLD;
                    shadow_d = tgt_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    en_d  = 1'b1;
                end
            end
            HOLD: begin
                state_d = IDLE;
                j_d     = '0;
                k_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign tgt_ready = (state_q == IDLE) & ~q_sync & ~rst;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == HOLD);
    assign en        = en_q;
    assign J         = j_q;
    assign K         = k_q;
    assign cur_q     = shadow_q;

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Self-checking bench for jk_drive_sequencer: directed scenarios plus randomized updates against a transition model.
module tb_jk_drive_sequencer;

    localparam int SETTLE = 2;
    localparam int BUDGET = 300;
`ifdef JK_TOGGLE_DRIVE_EN
    localparam bit TOG   = 1'b1;
    localparam int S_EFF = 1;
`else
    localparam bit TOG   = 1'b0;
    localparam int S_EFF = SETTLE;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic [3:0] tgt_data = 4'h0;
    logic       q_sync = 1'b0;
    logic [3:0] Q_fb = 4'h0;
    logic [3:0] J, K, cur_q;
    logic       en, busy, done;

    int checks = 0;
    int errors = 0;
    logic [3:0] model_cur = 4'h0;

    jk_drive_sequencer #(.WIDTH(4), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .tgt_data(tgt_data), .q_sync(q_sync), .Q_fb(Q_fb), .J(J), .K(K),
        .en(en), .cur_q(cur_q), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Expected outcome of one update, from the transition table and the latency rules.
    function automatic void model_update(input logic [3:0] c, input logic [3:0] t,
                                         output logic [3:0] ej, output logic [3:0] ek,
                                         output int een, output int edone, output int eready);
        logic [3:0] d;
        d = c ^ t;
        if (d == 4'h0) begin
            ej = 4'h0; ek = 4'h0; een = 0; edone = 1; eready = 2;
        end else begin
            if (TOG) begin ej = d; ek = d; end
            else begin ej = t & ~c; ek = c & ~t; end
            een = S_EFF; edone = 2 + S_EFF; eready = 3 + S_EFF;
        end
    endfunction

    // Offers target t at the current negedge (block idle) and records what the DUT does.
    task automatic drive_update(input logic [3:0] t, output logic [3:0] oj, output logic [3:0] ok,
                                output int en_cnt, output int en_first, output int done_cyc,
                                output int ready_cyc, output logic [3:0] cur_done,
                                output logic jk_stable, output logic [3:0] jk_idle);
        en_cnt = 0; en_first = -1; done_cyc = -1; ready_cyc = -1;
        cur_done = 4'hx; jk_stable = 1'b1; jk_idle = 4'hx;
        tgt_valid = 1'b1; tgt_data = t;
        @(negedge clk);
        tgt_valid = 1'b0; tgt_data = 4'($urandom);
        oj = J; ok = K;
        for (int cyc = 1; cyc < BUDGET; cyc++) begin
            if (en === 1'b1) begin en_cnt++; if (en_first < 0) en_first = cyc; end
            if (done === 1'b1 && done_cyc < 0) begin done_cyc = cyc; cur_done = cur_q; end
            if (busy === 1'b1 && (J !== oj || K !== ok)) jk_stable = 1'b0;
            if (tgt_ready === 1'b1) begin ready_cyc = cyc; jk_idle = J | K; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (J !== 4'h0) begin errors++; $display("FAIL reset_J got %h exp 0", J); end
        checks++; if (K !== 4'h0) begin errors++; $display("FAIL reset_K got %h exp 0", K); end
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", en); end
        checks++; if (cur_q !== 4'h0) begin errors++; $display("FAIL reset_cur got %h exp 0", cur_q); end
        checks++; if (tgt_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst got %b exp 0", tgt_ready); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b exp 00", busy, done); end
        rst = 1'b0;
        #1;
        checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b exp 1", tgt_ready); end
        @(negedge clk);
        model_cur = 4'h0;
    endtask

    task automatic test_set();
        logic [3:0] oj, ok, cd, jki; int ec, ef, dc, rc; logic st;
        drive_update(4'hA, oj, ok, ec, ef, dc, rc, cd, st, jki);
        checks++; if (oj !== 4'hA) begin errors++; $display("FAIL set_J got %h exp a", oj); end
        checks++; if (ok !== (TOG ? 4'hA : 4'h0)) begin errors++; $display("FAIL set_K got %h", ok); end
        checks++; if (ef !== 2) begin errors++; $display("FAIL set_en_first got %0d exp 2", ef); end
        checks++; if (ec !== S_EFF) begin errors++; $display("FAIL set_en_cnt got %0d exp %0d", ec, S_EFF); end
        checks++; if (dc !== 2 + S_EFF) begin errors++; $display("FAIL set_done_cyc got %0d exp %0d", dc, 2 + S_EFF); end
        checks++; if (rc !== 3 + S_EFF) begin errors++; $display("FAIL set_ready_cyc got %0d exp %0d", rc, 3 + S_EFF); end
        checks++; if (cd !== 4'hA) begin errors++; $display("FAIL set_cur_at_done got %h exp a", cd); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL set_jk_stable got %b exp 1", st); end
        checks++; if (jki !== 4'h0) begin errors++; $display("FAIL set_jk_idle got %h exp 0", jki); end
        model_cur = 4'hA;
    endtask

    task automatic test_mixed();
        logic [3:0] oj, ok, cd, jki; int ec, ef, dc, rc; logic st;
        drive_update(4'h5, oj, ok, ec, ef, dc, rc, cd, st, jki);
        checks++; if (oj !== (TOG ? 4'hF : 4'h5)) begin errors++; $display("FAIL mixed_J got %h", oj); end
        checks++; if (ok !== (TOG ? 4'hF : 4'hA)) begin errors++; $display("FAIL mixed_K got %h", ok); end
        checks++; if (ec !== S_EFF) begin errors++; $display("FAIL mixed_en_cnt got %0d exp %0d", ec, S_EFF); end
        checks++; if (cur_q !== 4'h5) begin errors++; $display("FAIL mixed_cur got %h exp 5", cur_q); end
        model_cur = 4'h5;
    endtask

    task automatic test_no_change();
        logic [3:0] oj, ok, cd, jki; int ec, ef, dc, rc; logic st;
        drive_update(4'h5, oj, ok, ec, ef, dc, rc, cd, st, jki);
        checks++; if (ec !== 0) begin errors++; $display("FAIL nochg_en_cnt got %0d exp 0", ec); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL nochg_done_cyc got %0d exp 1", dc); end
        checks++; if (rc !== 2) begin errors++; $display("FAIL nochg_ready_cyc got %0d exp 2", rc); end
        checks++; if ((oj | ok) !== 4'h0) begin errors++; $display("FAIL nochg_jk got %h/%h exp 0/0", oj, ok); end
        checks++; if (cur_q !== 4'h5) begin errors++; $display("FAIL nochg_cur got %h exp 5", cur_q); end
    endtask

    task automatic test_collision();
        int rc;
        q_sync = 1'b1; Q_fb = 4'h3; tgt_valid = 1'b1; tgt_data = 4'hC;
        #1;
        checks++; if (tgt_ready !== 1'b0) begin errors++; $display("FAIL coll_ready got %b exp 0", tgt_ready); end
        @(negedge clk);
        q_sync = 1'b0; Q_fb = 4'h0;
        #1;
        checks++; if (cur_q !== 4'h3) begin errors++; $display("FAIL coll_cur got %h exp 3", cur_q); end
        checks++; if (busy !== 1'b0 || tgt_ready !== 1'b1) begin errors++; $display("FAIL coll_not_taken got busy=%b ready=%b exp 0 1", busy, tgt_ready); end
        @(negedge clk);
        tgt_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL coll_accept_next got %b exp 1", busy); end
        checks++; if (J !== (TOG ? 4'hF : 4'hC) || K !== (TOG ? 4'hF : 4'h3)) begin errors++; $display("FAIL coll_jk got %h/%h", J, K); end
        @(negedge clk);
        q_sync = 1'b1; Q_fb = 4'h6;
        @(negedge clk);
        q_sync = 1'b0;
        rc = -1;
        for (int i = 0; i < BUDGET; i++) begin
            if (tgt_ready === 1'b1) begin rc = i; break; end
            @(negedge clk);
        end
        checks++; if (rc < 0) begin errors++; $display("FAIL coll_timeout got no ready exp ready"); end
        checks++; if (cur_q !== 4'hC) begin errors++; $display("FAIL coll_sync_ignored got %h exp c", cur_q); end
        model_cur = 4'hC;
    endtask

    task automatic test_random();
        logic [3:0] oj, ok, cd, jki, t, ej, ek, r; int ec, ef, dc, rc, een, edone, erdy; logic st;
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = 4'($urandom);
                q_sync = 1'b1; Q_fb = r;
                @(negedge clk);
                q_sync = 1'b0; Q_fb = 4'($urandom);
                checks++; if (cur_q !== r) begin errors++; $display("FAIL rnd_sync it%0d got %h exp %h", it, cur_q, r); end
                model_cur = r;
            end
            t = ($urandom_range(0, 4) == 0) ? model_cur : 4'($urandom);
            model_update(model_cur, t, ej, ek, een, edone, erdy);
            drive_update(t, oj, ok, ec, ef, dc, rc, cd, st, jki);
            checks++; if (oj !== ej || ok !== ek) begin errors++; $display("FAIL rnd_jk it%0d got %h/%h exp %h/%h", it, oj, ok, ej, ek); end
            checks++; if (ec !== een) begin errors++; $display("FAIL rnd_en_cnt it%0d got %0d exp %0d", it, ec, een); end
            checks++; if (dc !== edone || rc !== erdy) begin errors++; $display("FAIL rnd_latency it%0d got %0d/%0d exp %0d/%0d", it, dc, rc, edone, erdy); end
            checks++; if (cd !== t || cur_q !== t) begin errors++; $display("FAIL rnd_cur it%0d got %h/%h exp %h", it, cd, cur_q, t); end
            checks++; if (st !== 1'b1 || jki !== 4'h0) begin errors++; $display("FAIL rnd_jk_hold it%0d got %b/%h exp 1/0", it, st, jki); end
            model_cur = t;
        end
    endtask

    task automatic test_mid_reset();
        logic done_seen;
        q_sync = 1'b1; Q_fb = 4'h9;
        @(negedge clk);
        q_sync = 1'b0;
        tgt_valid = 1'b1; tgt_data = 4'h6;
        @(negedge clk);
        tgt_valid = 1'b0;
        @(negedge clk);
        checks++; if (en !== 1'b1) begin errors++; $display("FAIL midrst_en_before got %b exp 1", en); end
        #2 rst = 1'b1;
        #1;
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL midrst_en got %b exp 0", en); end
        checks++; if (cur_q !== 4'h0) begin errors++; $display("FAIL midrst_cur got %h exp 0", cur_q); end
        checks++; if (busy !== 1'b0 || (J | K) !== 4'h0) begin errors++; $display("FAIL midrst_idle got busy=%b jk=%h exp 0 0", busy, J | K); end
        done_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0) done_seen = 1'b1;
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 if (done !== 1'b0) done_seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL midrst_done got pulse exp none"); end
        checks++; if (tgt_ready !== 1'b1 || cur_q !== 4'h0) begin errors++; $display("FAIL midrst_after got ready=%b cur=%h exp 1 0", tgt_ready, cur_q); end
        model_cur = 4'h0;
    endtask

    initial begin
        test_reset();
        test_set();
        test_mixed();
        test_no_change();
        test_collision();
        test_random();
        test_mid_reset();
        test_set();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
